// File: rtl/tag_free_list.sv
// Tag free-list: pops one free tag per cycle and reclaims up to NUM_RET
// returned tags per cycle, with occupancy flags and sticky error status.
module tag_free_list #(
  parameter int unsigned TAG_WIDTH = 6,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned NUM_RET   = 2,
  parameter int unsigned AE_THRESH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_RET*TAG_WIDTH-1:0] cdb_tag_tf,
  input  logic [NUM_RET-1:0]           cdb_tag_tf_valid,
  input  logic                         ren_tf,
  output logic [TAG_WIDTH-1:0]         tagout_tf,
  output logic                         tagout_valid_tf,
  output logic                         ff_tf,
  output logic                         ef_tf,
  output logic                         ae_tf,
  output logic [$clog2(DEPTH):0]       count_tf,
  output logic                         underflow_err,
  output logic                         overflow_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned FW = CW + 1;

  logic [TAG_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]        rp;
  logic [PW-1:0]        wp;
  logic                 pop_ok;
  logic [FW-1:0]        free_slots;
  logic [FW-1:0]        push_cnt;
  logic [NUM_RET-1:0]   lane_we;
  logic [PW-1:0]        lane_addr [NUM_RET];
  logic                 drop;

  // Only tags present at the start of the cycle can be popped, so a return
  // into an empty list never satisfies a same-cycle request.
  assign pop_ok     = ren_tf && (count_tf != '0);
  assign free_slots = FW'(DEPTH) - {1'b0, count_tf} + FW'(pop_ok);

  // Compact valid lanes in lane order; once free space runs out the
  // remaining (higher) lanes are the ones dropped.
  always_comb begin
    push_cnt = '0;
    drop     = 1'b0;
    for (int unsigned k = 0; k < NUM_RET; k++) begin
      lane_we[k]   = 1'b0;
      lane_addr[k] = wp;
      if (cdb_tag_tf_valid[k]) begin
        if (push_cnt < free_slots) begin
          lane_we[k]   = 1'b1;
          lane_addr[k] = wp + push_cnt[PW-1:0];
          push_cnt     = push_cnt + 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= TAG_WIDTH'(i);
      end
      rp              <= '0;
      wp              <= '0;
      count_tf        <= CW'(DEPTH);
      tagout_valid_tf <= 1'b0;
      if (reset) begin
        tagout_tf     <= '0;
        underflow_err <= 1'b0;
        overflow_err  <= 1'b0;
      end
    end else begin
      tagout_valid_tf <= pop_ok;
      if (pop_ok) begin
        tagout_tf <= mem[rp];
        rp        <= rp + 1'b1;
      end
      if (ren_tf && !pop_ok) begin
        underflow_err <= 1'b1;
      end
      if (drop) begin
        overflow_err <= 1'b1;
      end
      for (int unsigned k = 0; k < NUM_RET; k++) begin
        if (lane_we[k]) begin
          mem[lane_addr[k]] <= cdb_tag_tf[k*TAG_WIDTH +: TAG_WIDTH];
        end
      end
      wp       <= wp + push_cnt[PW-1:0];
      count_tf <= count_tf - CW'(pop_ok) + push_cnt[CW-1:0];
    end
  end

  assign ff_tf = (count_tf == CW'(DEPTH));
  assign ef_tf = (count_tf == '0);
  assign ae_tf = (32'(count_tf) <= AE_THRESH);

endmodule

// File: tb/tb_tag_free_list.sv
// Self-checking bench for tag_free_list: directed scenarios plus random
// traffic, all checked against a queue-based model of the free list.
module tb_tag_free_list;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [11:0] cdb_tag_tf;
  logic [1:0]  cdb_tag_tf_valid;
  logic        ren_tf;
  logic [5:0]  tagout_tf;
  logic        tagout_valid_tf;
  logic        ff_tf;
  logic        ef_tf;
  logic        ae_tf;
  logic [6:0]  count_tf;
  logic        underflow_err;
  logic        overflow_err;

  tag_free_list #(.TAG_WIDTH(6), .DEPTH(64), .NUM_RET(2), .AE_THRESH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .cdb_tag_tf(cdb_tag_tf), .cdb_tag_tf_valid(cdb_tag_tf_valid),
    .ren_tf(ren_tf), .tagout_tf(tagout_tf), .tagout_valid_tf(tagout_valid_tf),
    .ff_tf(ff_tf), .ef_tf(ef_tf), .ae_tf(ae_tf), .count_tf(count_tf),
    .underflow_err(underflow_err), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: the free list is simply an ordered queue of tags.
  int         q[$];
  logic [5:0] m_tag;
  logic       m_valid, m_uf, m_of;

  wire [18:0] obs = {tagout_tf, tagout_valid_tf, count_tf, ff_tf, ef_tf, ae_tf,
                     underflow_err, overflow_err};

  function automatic logic [18:0] expv();
    return {m_tag, m_valid, 7'(q.size()), q.size() == 64, q.size() == 0,
            q.size() <= 4, m_uf, m_of};
  endfunction

  function automatic void model_fill();
    q.delete();
    for (int i = 0; i < 64; i++) q.push_back(i);
  endfunction

  task automatic step(input logic r, input logic f, input logic rd,
                      input logic [1:0] v, input logic [5:0] t0, input logic [5:0] t1);
    reset = r; flush = f; ren_tf = rd; cdb_tag_tf_valid = v; cdb_tag_tf = {t1, t0};
    @(posedge clk);
    if (r) begin
      model_fill();
      m_tag = '0; m_valid = 1'b0; m_uf = 1'b0; m_of = 1'b0;
    end else if (f) begin
      model_fill();
      m_valid = 1'b0;
    end else begin
      if (rd && q.size() > 0) begin
        m_tag   = 6'(q.pop_front());
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
        if (rd) m_uf = 1'b1;
      end
      if (v[0]) begin
        if (q.size() < 64) q.push_back(int'(t0)); else m_of = 1'b1;
      end
      if (v[1]) begin
        if (q.size() < 64) q.push_back(int'(t1)); else m_of = 1'b1;
      end
    end
    #1;
    reset = 1'b0; flush = 1'b0; ren_tf = 1'b0; cdb_tag_tf_valid = '0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 2'b00, 0, 0);
    vectors++;
    if (obs !== expv()) begin
      errors++; $display("FAIL reset: got %h want %h", obs, expv());
    end
    vectors++;
    if ({count_tf, ff_tf, ef_tf, ae_tf, tagout_valid_tf} !== {7'd64, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_const: got cnt=%0d ff=%b ef=%b ae=%b v=%b want 64 1 0 0 0",
               count_tf, ff_tf, ef_tf, ae_tf, tagout_valid_tf);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 65; i++) begin
      step(0, 0, 1, 2'b00, 0, 0);
      vectors++;
      if (obs !== expv()) begin
        errors++; $display("FAIL drain[%0d]: got %h want %h", i, obs, expv());
      end
    end
    vectors++;
    if ({tagout_valid_tf, underflow_err, ef_tf, count_tf} !== {1'b0, 1'b1, 1'b1, 7'd0}) begin
      errors++;
      $display("FAIL drain_underflow: got v=%b uf=%b ef=%b cnt=%0d want 0 1 1 0",
               tagout_valid_tf, underflow_err, ef_tf, count_tf);
    end
  endtask

  task automatic test_empty_return();
    logic [5:0] want [2];
    want[0] = 6'd9; want[1] = 6'd3;
    step(0, 0, 1, 2'b11, 6'd9, 6'd3);
    vectors++;
    if (obs !== expv() || count_tf !== 7'd2 || tagout_valid_tf !== 1'b0) begin
      errors++; $display("FAIL empty_ret: got %h want %h", obs, expv());
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 1, 2'b00, 0, 0);
      vectors++;
      if (obs !== expv() || tagout_tf !== want[i]) begin
        errors++; $display("FAIL empty_ret_pop[%0d]: got %h want %h (tag %0d)", i, obs, expv(), want[i]);
      end
    end
  endtask

  task automatic test_full_return();
    step(1, 0, 0, 2'b00, 0, 0);
    step(0, 0, 1, 2'b11, 6'd5, 6'd7);
    vectors++;
    if (obs !== expv() || tagout_tf !== 6'd0 || overflow_err !== 1'b1 || count_tf !== 7'd64) begin
      errors++; $display("FAIL full_ret: got %h want %h", obs, expv());
    end
    for (int i = 0; i < 64; i++) begin
      step(0, 0, 1, 2'b00, 0, 0);
      vectors++;
      if (obs !== expv()) begin
        errors++; $display("FAIL full_ret_pop[%0d]: got %h want %h", i, obs, expv());
      end
    end
    vectors++;
    if (tagout_tf !== 6'd5) begin
      errors++; $display("FAIL full_ret_last: got %0d want 5", tagout_tf);
    end
  endtask

  task automatic test_wrap();
    step(1, 0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 60; i++) step(0, 0, 1, 2'b00, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 2'b11, 6'(40 + 2*i), 6'(41 + 2*i));
      vectors++;
      if (obs !== expv()) begin
        errors++; $display("FAIL wrap_ret[%0d]: got %h want %h", i, obs, expv());
      end
    end
    for (int i = 0; i < 24; i++) begin
      step(0, 0, 1, 2'b00, 0, 0);
      vectors++;
      if (obs !== expv() || tagout_tf !== 6'(i < 4 ? 60 + i : 36 + i)) begin
        errors++; $display("FAIL wrap_pop[%0d]: got %h want %h", i, obs, expv());
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 10; i++) step(0, 0, 1, 2'b00, 0, 0);
    step(0, 1, 1, 2'b01, 6'd33, 0);
    vectors++;
    if (obs !== expv() || tagout_valid_tf !== 1'b0 || count_tf !== 7'd64) begin
      errors++; $display("FAIL flush: got %h want %h", obs, expv());
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 2'b00, 0, 0);
      vectors++;
      if (obs !== expv() || tagout_tf !== 6'(i)) begin
        errors++; $display("FAIL flush_pop[%0d]: got %h want %h", i, obs, expv());
      end
    end
  endtask

  task automatic test_random();
    logic rd, f, r;
    logic [1:0] v;
    int pr, pv;
    for (int i = 0; i < 3000; i++) begin
      // Alternate drain-heavy and fill-heavy phases to hit both extremes.
      if ((i / 150) % 2 == 0) begin pr = 85; pv = 30; end else begin pr = 25; pv = 75; end
      rd = ($urandom_range(0, 99) < pr);
      v  = {($urandom_range(0, 99) < pv), ($urandom_range(0, 99) < pv)};
      f  = ($urandom_range(0, 999) < 5);
      r  = ($urandom_range(0, 999) < 2);
      step(r, f, rd, v, 6'($urandom), 6'($urandom));
      vectors++;
      if (obs !== expv()) begin
        errors++; $display("FAIL random[%0d]: got %h want %h", i, obs, expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 2'b00, 0, 0);
    step(0, 0, 0, 2'b01, 6'd12, 0);
    for (int i = 0; i < 47; i++) step(0, 0, 1, 2'b00, 0, 0);
    vectors++;
    if (obs !== expv() || count_tf !== 7'd17 || overflow_err !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre: got %h want %h", obs, expv());
    end
    step(1, 0, 1, 2'b11, 6'd1, 6'd2);
    vectors++;
    if (obs !== expv() ||
        {count_tf, overflow_err, underflow_err, tagout_tf, tagout_valid_tf} !== {7'd64, 1'b0, 1'b0, 6'd0, 1'b0}) begin
      errors++; $display("FAIL reset_mid: got %h want %h", obs, expv());
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; ren_tf = 1'b0; cdb_tag_tf = '0; cdb_tag_tf_valid = '0;
    m_tag = '0; m_valid = 1'b0; m_uf = 1'b0; m_of = 1'b0;
    model_fill();
    @(negedge clk);
    test_reset();
    test_drain();
    test_empty_return();
    test_full_return();
    test_wrap();
    test_flush();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
